// File: rtl/fec_hamming_decoder_pkg.sv
// rtl/fec_hamming_decoder_pkg.sv - shared Hamming(7,4) constants and decoder state type
package fec_hamming_decoder_pkg;

  localparam int HAM_CW_W   = 7;
  localparam int HAM_DATA_W = 4;

  // Bit i of a mask selects Hamming position i+1 for that syndrome bit
  localparam logic [HAM_CW_W-1:0] SYN_MASK0 = 7'h55;
  localparam logic [HAM_CW_W-1:0] SYN_MASK1 = 7'h66;
  localparam logic [HAM_CW_W-1:0] SYN_MASK2 = 7'h78;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    DEC,
    ACK
  } dec_state_t;

endpackage

// File: rtl/fec_hamming_decoder_syndrome.sv
// rtl/fec_hamming_decoder_syndrome.sv - combinational Hamming(7,4) syndrome and single-bit correction
module hamming74_syndrome
  import fec_hamming_decoder_pkg::*;
(
  input  logic [HAM_CW_W-1:0]   codeword,
  output logic [2:0]            syndrome,
  output logic [HAM_DATA_W-1:0] data
);

  logic [HAM_CW_W-1:0] fixed;

  always_comb begin
    syndrome = {^(codeword & SYN_MASK2), ^(codeword & SYN_MASK1), ^(codeword & SYN_MASK0)};
    fixed    = codeword;
    // A non-zero syndrome names the 1-based position of the flipped bit
    for (int i = 0; i < HAM_CW_W; i++) begin
      if (syndrome == 3'(i + 1)) begin
        fixed[i] = ~codeword[i];
      end
    end
    data = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

endmodule

// File: rtl/fec_hamming_decoder.sv
// rtl/fec_hamming_decoder.sv - Hamming(7,4) burst decoder with 4-phase req/ack handshake
module fec_hamming_decoder
  import fec_hamming_decoder_pkg::*;
#(
  parameter int CW_W   = 7,
  parameter int DATA_W = 4,
  parameter int BURST  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req,
  output logic              ack,
  input  logic              buff_empty,
  output logic              rd_en_buff,
  input  logic [CW_W-1:0]   codeword_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              err_detected,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int WC_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(BURST - 1);

  dec_state_t        state, next_state;
  logic [WC_W-1:0]   word_cnt;
  logic              valid_q;
  logic              err_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [2:0]        syndrome;
  logic [DATA_W-1:0] fixed_data;

  hamming74_syndrome u_syndrome (
    .codeword (codeword_in),
    .syndrome (syndrome),
    .data     (fixed_data)
  );

  always_comb begin
    next_state = state;
    rd_en_buff = 1'b0;
    unique case (state)
      IDLE: if (req) next_state = READ;
      READ: begin
        rd_en_buff = en && !buff_empty;
        if (!buff_empty) next_state = CAPT;
      end
      CAPT: next_state = DEC;
      DEC:  next_state = (word_cnt == LAST_WORD) ? ACK : READ;
      ACK:  if (!req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decode happens on the CAPT edge so the registered result is presented during DEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      err_cnt_q <= '0;
    end else if (en) begin
      state   <= next_state;
      valid_q <= (state == CAPT);
      if (state == IDLE && req) begin
        word_cnt <= '0;
      end
      if (state == DEC && word_cnt != LAST_WORD) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (state == CAPT) begin
        data_q <= fixed_data;
        err_q  <= (syndrome != 3'd0);
        if (syndrome != 3'd0 && err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
    end
  end

  assign data_valid   = en && valid_q;
  assign err_detected = data_valid && err_q;
  assign data_out     = data_q;
  assign err_cnt      = err_cnt_q;
  assign ack          = (state == ACK);
  assign busy         = (state != IDLE);

endmodule
